mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants allowed while an instruction request waits (used only with MEM_ARB_FAIR_EN).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, ports listed below.
REQ-003 clk_i  in  1  sole clock; all state on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 i_req_i  in  1  instruction fetch request.
REQ-006 i_addr_i  in  32  fetch address.
REQ-007 i_gnt_o  out  1  one-cycle pulse: fetch request captured.
REQ-008 i_rvalid_o  out  1  fetch data valid on rdata_o.
REQ-009 d_req_i  in  1  data access request.
REQ-010 d_we_i  in  1  1 = store, 0 = load.
REQ-011 d_addr_i  in  32  data address.
REQ-012 d_wdata_i  in  32  store data.
REQ-013 d_be_i  in  4  store/load byte enables.
REQ-014 d_gnt_o  out  1  one-cycle pulse: data request captured.
REQ-015 d_rvalid_o  out  1  data access complete; load data valid on rdata_o.
REQ-016 rdata_o  out  32  read data, combinational copy of m_rdata_i.
REQ-017 m_req_o  out  1  unified memory port request.
REQ-018 m_we_o / m_be_o  out  1 / 4  memory write enable / byte enables.
REQ-019 m_addr_o / m_wdata_o  out  32 / 32  memory address / write data.
REQ-020 m_gnt_i  in  1  memory accepted current request.
REQ-021 m_rvalid_i / m_rdata_i  in  1 / 32  memory response valid / read data (response issued for loads and stores).

Function
REQ-022 SHALL implement FSM IDLE -> WAIT_GNT -> WAIT_RSP -> IDLE with at most one outstanding transaction.
REQ-023 IDLE: if d_req_i or i_req_i, SHALL register the winner's fields into m_* outputs, pulse its *_gnt_o that same cycle, go WAIT_GNT; m_req_o asserts the following cycle (latency 1).
REQ-024 Arbitration SHALL give data priority over instruction when both request in the same cycle.
REQ-025 Instruction transactions SHALL drive m_we_o=0, m_be_o=4'hF, m_wdata_o=0.
REQ-026 WAIT_GNT: m_req_o and all m_* fields SHALL hold stable until m_gnt_i=1, then m_req_o deasserts and FSM goes WAIT_RSP.
REQ-027 WAIT_RSP: on m_rvalid_i=1 SHALL assert i_rvalid_o or d_rvalid_o (owner only, combinational, same cycle) and re-arbitrate in that same cycle, allowing back-to-back m_req_o.
REQ-028 i_rvalid_o/d_rvalid_o SHALL be 0 outside WAIT_RSP; m_rvalid_i in IDLE or WAIT_GNT SHALL be ignored.
REQ-029 Requests changing after *_gnt_o SHALL NOT affect the captured transaction; requesters drop or advance req after gnt.

Reset
REQ-030 On reset_i=0, SHALL asynchronously enter IDLE; m_req_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o =0; m_addr_o, m_wdata_o =0; m_we_o=0; m_be_o=0; starvation counter=0.
REQ-031 Reset mid-transaction SHALL abandon it; a late m_rvalid_i after release SHALL produce no *_rvalid_o.

Configuration
REQ-032 With MEM_ARB_FAIR_EN defined, a counter SHALL count data grants made while i_req_i=1, clear on any instruction grant or when i_req_i=0, and at STARVE_LIMIT the next arbitration SHALL grant instruction despite d_req_i.
REQ-033 Without MEM_ARB_FAIR_EN, arbitration SHALL be strict data priority and no counter logic SHALL exist.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the FSM state enum, the owner enum (OWN_I, OWN_D) and the STARVE_LIMIT default constant.
REQ-035 Starvation counter SHALL be sub-module mem_arb_fair_ctr, instantiated only under MEM_ARB_FAIR_EN.

Verification
REQ-036 Fetch only, i_addr_i=0x100, m_gnt_i next cycle, m_rvalid_i with 0xDEADBEEF two cycles later -> m_addr_o=0x100, m_be_o=4'hF, i_rvalid_o=1, rdata_o=0xDEADBEEF.
REQ-037 i_req_i and d_req_i same cycle, d_we_i=1, d_addr_i=0x2000, d_wdata_i=0x55AA, d_be_i=4'h3 -> d_gnt_o first, m_we_o=1 with those fields; fetch granted on cycle of d_rvalid_o.
REQ-038 m_gnt_i held low 5 cycles -> m_req_o and m_addr_o stable all 5 cycles; single transaction issued.
REQ-039 MEM_ARB_FAIR_EN, STARVE_LIMIT=4, d_req_i and i_req_i continuously high -> grant order D,D,D,D,I,D...; without macro -> D only.
REQ-040 reset_i low during WAIT_RSP, m_rvalid_i pulse after release -> all outputs at reset values, no *_rvalid_o.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the transaction FSM state encoding, the transaction owner encoding
// and the default fairness limit used when MEM_ARB_FAIR_EN is defined.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RSP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 32'd4;

  // Counter width able to hold values 0..limit (at least one bit).
  function automatic int unsigned ctr_width(input int unsigned limit);
    return (limit < 32'd1) ? 32'd1 : $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/mem_arb_fair_ctr.sv
// Fetch starvation counter for mem_port_arbiter (built only with
// MEM_ARB_FAIR_EN). Counts data grants issued while a fetch is waiting and
// raises o_force_i once STARVE_LIMIT such grants have been made in a row.
module mem_arb_fair_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ireq,
  input  logic i_d_gnt,
  input  logic i_i_gnt,
  output logic o_force_i
);

  localparam int unsigned    CW    = ctr_width(STARVE_LIMIT);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0]  ONE   = CW'(1);

  logic [CW-1:0] r_cnt;

  // Count data grants while fetch waits; clear on fetch grant or idle fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_ireq || i_i_gnt) begin
      r_cnt <= '0;
    end else if (i_d_gnt && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_force_i = (r_cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto a single memory
// port with at most one outstanding transaction. Data wins ties; defining
// MEM_ARB_FAIR_EN adds a starvation counter that forces a fetch grant after
// STARVE_LIMIT consecutive data grants made while a fetch was waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_gnt_i,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i
);

  arb_state_e  r_state;
  owner_e      r_owner;
  logic        r_m_req;
  logic        r_m_we;
  logic [3:0]  r_m_be;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;

  logic        w_rsp;
  logic        w_arb_en;
  logic        w_force_i;
  logic        w_pick_i;
  logic        w_pick_d;

  // A response only counts while one is outstanding; it also frees the port.
  assign w_rsp    = (r_state == ST_WAIT_RSP) && m_rvalid_i;
  assign w_arb_en = (r_state == ST_IDLE) || w_rsp;

`ifdef MEM_ARB_FAIR_EN
  mem_arb_fair_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_fair_ctr (
    .i_clk     (clk_i),
    .i_rst_n   (reset_i),
    .i_ireq    (i_req_i),
    .i_d_gnt   (d_gnt_o),
    .i_i_gnt   (i_gnt_o),
    .o_force_i (w_force_i)
  );
`else
  logic w_unused_limit;
  assign w_unused_limit = (STARVE_LIMIT == 32'd0);
  assign w_force_i      = 1'b0;
`endif

  // Pick the winner: data first unless a starved fetch is being forced through.
  always_comb begin
    w_pick_i = 1'b0;
    w_pick_d = 1'b0;
    if (w_arb_en) begin
      if (i_req_i && (w_force_i || !d_req_i)) begin
        w_pick_i = 1'b1;
      end else if (d_req_i) begin
        w_pick_d = 1'b1;
      end else begin
        w_pick_i = 1'b0;
        w_pick_d = 1'b0;
      end
    end else begin
      w_pick_i = 1'b0;
      w_pick_d = 1'b0;
    end
  end

  assign i_gnt_o    = w_pick_i;
  assign d_gnt_o    = w_pick_d;
  assign i_rvalid_o = w_rsp && (r_owner == OWN_I);
  assign d_rvalid_o = w_rsp && (r_owner == OWN_D);
  assign rdata_o    = m_rdata_i;

  assign m_req_o    = r_m_req;
  assign m_we_o     = r_m_we;
  assign m_be_o     = r_m_be;
  assign m_addr_o   = r_m_addr;
  assign m_wdata_o  = r_m_wdata;

  // Transaction FSM: capture the winner, hold the request until accepted,
  // then wait for the response and immediately re-arbitrate on it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_I;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_be    <= 4'h0;
      r_m_addr  <= 32'h0;
      r_m_wdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WAIT_RSP: begin
          if (w_pick_d) begin
            r_owner   <= OWN_D;
            r_m_req   <= 1'b1;
            r_m_we    <= d_we_i;
            r_m_be    <= d_be_i;
            r_m_addr  <= d_addr_i;
            r_m_wdata <= d_wdata_i;
            r_state   <= ST_WAIT_GNT;
          end else if (w_pick_i) begin
            r_owner   <= OWN_I;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_be    <= 4'hF;
            r_m_addr  <= i_addr_i;
            r_m_wdata <= 32'h0;
            r_state   <= ST_WAIT_GNT;
          end else if (w_rsp) begin
            r_state   <= ST_IDLE;
          end else begin
            r_state   <= r_state;
          end
        end
        ST_WAIT_GNT: begin
          if (m_gnt_i) begin
            r_m_req <= 1'b0;
            r_state <= ST_WAIT_RSP;
          end else begin
            r_state <= ST_WAIT_GNT;
          end
        end
        default: begin
          r_m_req <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Stimulus pushes expected grants,
// memory requests and responses into queues; independent monitors pop and
// compare whenever the DUT presents a grant, an accepted request or a response.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] rdata_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic        m_gnt_i;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_gnt_o    (i_gnt_o),
    .i_rvalid_o (i_rvalid_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_be_i     (d_be_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .rdata_o    (rdata_o),
    .m_req_o    (m_req_o),
    .m_we_o     (m_we_o),
    .m_be_o     (m_be_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_gnt_i    (m_gnt_i),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_gnt_q[$];   // {check d_rvalid on this grant, is_data}
  logic [68:0] exp_req_q[$];   // {we, be, addr, wdata}
  logic [32:0] exp_rsp_q[$];   // {is_data, rdata}
  logic [31:0] rd_data_q[$];   // data the memory model returns

  int gnt_delay  = 0;
  int rsp_delay  = 1;
  bit late_pulse = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, {55'd0, m_req_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o,
                 m_we_o, m_be_o, m_addr_o, m_wdata_o}, 128'd0);
  endtask

  task automatic push_txn(input bit is_d, input bit chk_rv, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input bit has_rsp);
    exp_gnt_q.push_back({chk_rv, is_d});
    exp_req_q.push_back({we, be, addr, wdata});
    if (has_rsp) begin
      exp_rsp_q.push_back({is_d, rdata});
      rd_data_q.push_back(rdata);
    end
  endtask

  // Grant monitor.
  initial begin : mon_gnt
    logic [1:0] e;
    forever begin
      @(negedge clk_i);
      if (i_gnt_o || d_gnt_o) begin
        if (exp_gnt_q.size() == 0) begin
          check("unexpected_gnt", {126'd0, i_gnt_o, d_gnt_o}, 128'd0);
        end else begin
          e = exp_gnt_q.pop_front();
          check("gnt_owner", {126'd0, i_gnt_o, d_gnt_o}, e[0] ? 128'd1 : 128'd2);
          if (e[1]) check("gnt_on_d_rvalid", {127'd0, d_rvalid_o}, 128'd1);
        end
      end
    end
  end

  // Memory request monitor: compares fields when the memory accepts.
  initial begin : mon_req
    logic [68:0] e;
    forever begin
      @(negedge clk_i);
      if (m_req_o && m_gnt_i) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_mreq", {59'd0, m_we_o, m_be_o, m_addr_o, m_wdata_o}, 128'd0);
        end else begin
          e = exp_req_q.pop_front();
          check("mreq_fields", {59'd0, m_we_o, m_be_o, m_addr_o, m_wdata_o}, {59'd0, e});
        end
      end
    end
  end

  // Response monitor.
  initial begin : mon_rsp
    logic [32:0] e;
    forever begin
      @(negedge clk_i);
      if (i_rvalid_o || d_rvalid_o) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_rvalid", {126'd0, i_rvalid_o, d_rvalid_o}, 128'd0);
        end else begin
          e = exp_rsp_q.pop_front();
          check("rsp", {94'd0, d_rvalid_o, i_rvalid_o, rdata_o}, {94'd0, e[32], ~e[32], e[31:0]});
        end
      end
    end
  end

  // Memory model: grant after gnt_delay cycles, respond rsp_delay cycles later.
  initial begin : responder
    int cnt;
    int ph;
    cnt = 0;
    ph  = 0;
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      m_gnt_i    = 1'b0;
      m_rvalid_i = 1'b0;
      if (!reset_i) begin
        ph = 0;
      end else if (ph == 0) begin
        if (late_pulse) begin
          m_rvalid_i = 1'b1;
          m_rdata_i  = 32'h1234_5678;
          late_pulse = 1'b0;
        end else if (m_req_o) begin
          if (gnt_delay == 0) begin
            m_gnt_i = 1'b1;
            ph  = 2;
            cnt = rsp_delay;
          end else begin
            ph  = 1;
            cnt = gnt_delay;
          end
        end
      end else if (ph == 1) begin
        cnt--;
        if (cnt == 0) begin
          m_gnt_i = 1'b1;
          ph  = 2;
          cnt = rsp_delay;
        end
      end else begin
        if (cnt <= 1) begin
          m_rvalid_i = 1'b1;
          m_rdata_i  = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'h0;
          ph = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic wait_gnt(input bit is_d, input string name);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk_i);
      got = is_d ? d_gnt_o : i_gnt_o;
    end
    if (!got) check({name, "_gnt_timeout"}, 128'd0, 128'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    i_addr_i = addr;
    i_req_i  = 1'b1;
    wait_gnt(1'b0, "fetch");
    i_req_i  = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
    d_we_i    = we;
    d_be_i    = be;
    d_addr_i  = addr;
    d_wdata_i = wdata;
    d_req_i   = 1'b1;
    wait_gnt(1'b1, "data");
    d_req_i   = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      done = (exp_gnt_q.size() == 0) && (exp_req_q.size() == 0) &&
             (exp_rsp_q.size() == 0) && !m_req_o;
    end
    if (!done) check({name, "_drain_timeout"}, 128'd0, 128'd1);
    @(posedge clk_i);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit is_i;
    int seen;
    i_req_i   = 1'b0;
    i_addr_i  = 32'h0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_addr_i  = 32'h0;
    d_wdata_i = 32'h0;
    d_be_i    = 4'h0;
    reset_i   = 1'b1;
    #1 reset_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset("reset_state");
    @(posedge clk_i);
    #1 reset_i = 1'b1;

    // Fetch only: gnt next cycle, data two cycles later.
    gnt_delay = 0;
    rsp_delay = 2;
    push_txn(1'b0, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1);
    do_fetch(32'h100);
    drain("fetch_only");

    // Simultaneous requests: store first, fetch granted with d_rvalid_o.
    rsp_delay = 1;
    push_txn(1'b1, 1'b0, 1'b1, 4'h3, 32'h2000, 32'h55AA, 32'h0BAD_F00D, 1'b1);
    push_txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 32'hCAFE_0001, 1'b1);
    fork
      do_data(1'b1, 4'h3, 32'h2000, 32'h55AA);
      do_fetch(32'h300);
    join
    drain("tie");

    // Memory stalls grant for 5 cycles: request and fields hold.
    gnt_delay = 5;
    push_txn(1'b1, 1'b0, 1'b0, 4'hF, 32'h4000, 32'h0, 32'h1111_2222, 1'b1);
    do_data(1'b0, 4'hF, 32'h4000, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("stall_hold", {91'd0, m_req_o, m_we_o, m_be_o, m_addr_o},
            {91'd0, 1'b1, 1'b0, 4'hF, 32'h4000});
    end
    drain("stall");
    check("stall_single_txn", {127'd0, m_req_o}, 128'd0);

    // Both requesters held high for 10 grants.
    gnt_delay = 0;
    rsp_delay = 1;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIR_EN
      is_i = ((k % 5) == 4);
`else
      is_i = 1'b0;
`endif
      if (is_i) push_txn(1'b0, 1'b0, 1'b0, 4'hF, 32'h600, 32'h0, 32'hA000_0000 + k, 1'b1);
      else      push_txn(1'b1, 1'b0, 1'b1, 4'hC, 32'h5000, 32'h77, 32'hA000_0000 + k, 1'b1);
    end
    d_we_i    = 1'b1;
    d_be_i    = 4'hC;
    d_addr_i  = 32'h5000;
    d_wdata_i = 32'h77;
    i_addr_i  = 32'h600;
    d_req_i   = 1'b1;
    i_req_i   = 1'b1;
    seen = 0;
    for (int k = 0; k < 300 && seen < 10; k++) begin
      @(negedge clk_i);
      if (i_gnt_o || d_gnt_o) seen++;
    end
    if (seen < 10) check("stream_gnt_timeout", 128'(seen), 128'd10);
    @(posedge clk_i);
    #1;
    d_req_i = 1'b0;
    i_req_i = 1'b0;
    drain("stream");

    // Reset while waiting for a response, then a stray response.
    rsp_delay = 8;
    push_txn(1'b1, 1'b0, 1'b0, 4'hF, 32'h8000, 32'h0, 32'h0, 1'b0);
    do_data(1'b0, 4'hF, 32'h8000, 32'h0);
    @(posedge clk_i);
    #2 reset_i = 1'b0;
    @(negedge clk_i);
    check_reset("reset_mid_txn");
    @(posedge clk_i);
    #2;
    reset_i    = 1'b1;
    late_pulse = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset("late_rvalid_ignored");
    repeat (3) @(negedge clk_i);
    check("queues_empty", 128'(exp_gnt_q.size() + exp_req_q.size() + exp_rsp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
